// File: rtl/snake_video_compositor.sv
// Snake game pixel compositor and VGA output stage: layer priority merge, mode effects, aligned sync/colour pipeline.
// Optional line darkening is enabled by defining SNAKE_COMP_SCANLINE_EN.
module snake_video_compositor #(
    parameter int unsigned COLOR_W         = 4,
    parameter int unsigned LAYERS          = 3,
    parameter int unsigned PIPE            = 2,
    parameter int unsigned FLASH_PERIOD    = 15,
    parameter int unsigned FLASH_COUNT     = 3,
    parameter int unsigned SYNC_ACTIVE_LOW = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          pix_en,
    input  logic                          hsync_in,
    input  logic                          vsync_in,
    input  logic                          de_in,
    input  logic [LAYERS-1:0]             layer_hit,
    input  logic [LAYERS*3*COLOR_W-1:0]   layer_rgb,
    input  logic [3*COLOR_W-1:0]          bg_rgb,
    input  logic [3*COLOR_W-1:0]          over_rgb,
    input  logic [1:0]                    mode,
    output logic                          vga_hsync,
    output logic                          vga_vsync,
    output logic [COLOR_W-1:0]            vga_r,
    output logic [COLOR_W-1:0]            vga_g,
    output logic [COLOR_W-1:0]            vga_b,
    output logic                          frame_tick,
    output logic [1:0]                    state_o
);

    localparam int unsigned RGB_W = 3 * COLOR_W;
    localparam int unsigned FR_W  = 8;
    localparam int unsigned FL_W  = 4;
    localparam logic SYNC_IDLE    = (SYNC_ACTIVE_LOW != 0);

    localparam logic [1:0] ST_PLAY  = 2'b00;
    localparam logic [1:0] ST_PAUSE = 2'b01;
    localparam logic [1:0] ST_FLASH = 2'b10;
    localparam logic [1:0] ST_HOLD  = 2'b11;

    logic [1:0]      state, state_n;
    logic [FR_W-1:0] frame_ctr, frame_ctr_n;
    logic [FL_W-1:0] flash_ctr, flash_ctr_n, flash_inc;
    logic            phase, phase_n;
    logic            vs_prev;
    logic            vs_act, frame_start;
    logic            mode_play, mode_pause, mode_over;

    logic [RGB_W-1:0] base_rgb, fx_rgb, pix_rgb;
    logic [RGB_W-1:0] pipe_rgb [PIPE];
    logic [PIPE-1:0]  pipe_hs, pipe_vs;

    function automatic logic [RGB_W-1:0] halve(input logic [RGB_W-1:0] c);
        logic [RGB_W-1:0] res;
        for (int ch = 0; ch < 3; ch++) begin
            res[ch*COLOR_W +: COLOR_W] = c[ch*COLOR_W +: COLOR_W] >> 1;
        end
        return res;
    endfunction

    assign vs_act      = vsync_in ^ SYNC_IDLE;
    assign frame_start = pix_en & vs_act & ~vs_prev;
    assign mode_play   = (mode == 2'b00);
    assign mode_pause  = (mode == 2'b01);
    assign mode_over   = mode[1];
    assign flash_inc   = flash_ctr + FL_W'(1);

    // vs_prev resets to "active" so a vsync already held active is not taken as a frame start
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_PLAY;
            frame_ctr  <= '0;
            flash_ctr  <= '0;
            phase      <= 1'b0;
            vs_prev    <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_n;
            frame_ctr  <= frame_ctr_n;
            flash_ctr  <= flash_ctr_n;
            phase      <= phase_n;
            frame_tick <= frame_start;
            if (pix_en) begin
                vs_prev <= vs_act;
            end
        end
    end

    always_comb begin
        state_n     = state;
        frame_ctr_n = frame_ctr;
        flash_ctr_n = flash_ctr;
        phase_n     = phase;
        if (frame_start) begin
            case (state)
                ST_PLAY, ST_PAUSE: begin
                    if (mode_over) begin
                        state_n     = ST_FLASH;
                        frame_ctr_n = '0;
                        flash_ctr_n = '0;
                        phase_n     = 1'b0;
                    end else if (mode_pause) begin
                        state_n = ST_PAUSE;
                    end else begin
                        state_n = ST_PLAY;
                    end
                end
                ST_FLASH: begin
                    if (mode_play) begin
                        state_n     = ST_PLAY;
                        frame_ctr_n = '0;
                        flash_ctr_n = '0;
                        phase_n     = 1'b0;
                    end else if (frame_ctr == FR_W'(FLASH_PERIOD - 1)) begin
                        frame_ctr_n = '0;
                        phase_n     = ~phase;
                        // a full flash cycle completes when phase falls back to 0
                        if (phase) begin
                            flash_ctr_n = flash_inc;
                            if (flash_inc == FL_W'(FLASH_COUNT)) begin
                                state_n = ST_HOLD;
                            end
                        end
                    end else begin
                        frame_ctr_n = frame_ctr + FR_W'(1);
                    end
                end
                default: begin
                    if (mode_play) begin
                        state_n     = ST_PLAY;
                        frame_ctr_n = '0;
                        flash_ctr_n = '0;
                        phase_n     = 1'b0;
                    end
                end
            endcase
        end
    end

    // Lowest-index covered layer wins, background otherwise
    always_comb begin
        base_rgb = bg_rgb;
        for (int i = int'(LAYERS) - 1; i >= 0; i--) begin
            if (layer_hit[i]) begin
                base_rgb = layer_rgb[i*RGB_W +: RGB_W];
            end
        end
    end

    always_comb begin
        fx_rgb = base_rgb;
        case (state)
            ST_PAUSE: fx_rgb = halve(base_rgb);
            ST_FLASH: fx_rgb = phase ? over_rgb : base_rgb;
            ST_HOLD:  fx_rgb = over_rgb;
            default:  fx_rgb = base_rgb;
        endcase
    end

`ifdef SNAKE_COMP_SCANLINE_EN
    logic hs_prev;
    logic line_odd;
    logic hs_act;

    assign hs_act = hsync_in ^ SYNC_IDLE;

    always_ff @(posedge clk) begin
        if (reset) begin
            hs_prev  <= 1'b1;
            line_odd <= 1'b0;
        end else if (pix_en) begin
            hs_prev <= hs_act;
            if (frame_start) begin
                line_odd <= 1'b0;
            end else if (hs_act && !hs_prev) begin
                line_odd <= ~line_odd;
            end
        end
    end

    assign pix_rgb = de_in ? (line_odd ? halve(fx_rgb) : fx_rgb) : '0;
`else
    assign pix_rgb = de_in ? fx_rgb : '0;
`endif

    // Colour is de-qualified before entering the delay line, so stages only carry rgb and syncs
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(PIPE); i++) begin
                pipe_rgb[i] <= '0;
                pipe_hs[i]  <= SYNC_IDLE;
                pipe_vs[i]  <= SYNC_IDLE;
            end
        end else if (pix_en) begin
            pipe_rgb[0] <= pix_rgb;
            pipe_hs[0]  <= hsync_in;
            pipe_vs[0]  <= vsync_in;
            for (int i = 1; i < int'(PIPE); i++) begin
                pipe_rgb[i] <= pipe_rgb[i-1];
                pipe_hs[i]  <= pipe_hs[i-1];
                pipe_vs[i]  <= pipe_vs[i-1];
            end
        end
    end

    assign vga_hsync = pipe_hs[PIPE-1];
    assign vga_vsync = pipe_vs[PIPE-1];
    assign vga_r     = pipe_rgb[PIPE-1][RGB_W-1 -: COLOR_W];
    assign vga_g     = pipe_rgb[PIPE-1][2*COLOR_W-1 -: COLOR_W];
    assign vga_b     = pipe_rgb[PIPE-1][COLOR_W-1:0];
    assign state_o   = state;

endmodule

// File: tb/tb_snake_video_compositor.sv
// Directed bench for snake_video_compositor: PIPE=2 main instance plus a PIPE=4 instance for alignment.
module tb_snake_video_compositor;

    logic        clk = 1'b0;
    logic        reset;
    logic        pix_en;
    logic        hsync_in;
    logic        vsync_in;
    logic        de_in;
    logic [2:0]  layer_hit;
    logic [35:0] layer_rgb;
    logic [11:0] bg_rgb;
    logic [11:0] over_rgb;
    logic [1:0]  mode;

    logic        hs2, vs2, ft2;
    logic [3:0]  r2, g2, b2;
    logic [1:0]  st2;
    logic        hs4, vs4, ft4;
    logic [3:0]  r4, g4, b4;
    logic [1:0]  st4;
    logic [11:0] rgb2, rgb4;

    int passed = 0;
    int total  = 0;

    assign rgb2 = {r2, g2, b2};
    assign rgb4 = {r4, g4, b4};

    always #5 clk = ~clk;

    snake_video_compositor #(
        .COLOR_W(4), .LAYERS(3), .PIPE(2), .FLASH_PERIOD(2), .FLASH_COUNT(2), .SYNC_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .de_in(de_in), .layer_hit(layer_hit), .layer_rgb(layer_rgb), .bg_rgb(bg_rgb),
        .over_rgb(over_rgb), .mode(mode), .vga_hsync(hs2), .vga_vsync(vs2),
        .vga_r(r2), .vga_g(g2), .vga_b(b2), .frame_tick(ft2), .state_o(st2)
    );

    snake_video_compositor #(
        .COLOR_W(4), .LAYERS(3), .PIPE(4), .FLASH_PERIOD(2), .FLASH_COUNT(2), .SYNC_ACTIVE_LOW(1)
    ) dut4 (
        .clk(clk), .reset(reset), .pix_en(pix_en), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .de_in(de_in), .layer_hit(layer_hit), .layer_rgb(layer_rgb), .bg_rgb(bg_rgb),
        .over_rgb(over_rgb), .mode(mode), .vga_hsync(hs4), .vga_vsync(vs4),
        .vga_r(r4), .vga_g(g4), .vga_b(b4), .frame_tick(ft4), .state_o(st4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // One-pixel vsync pulse (active low) with de low; frame_tick must follow the capturing edge
    task automatic frame_start();
        vsync_in = 1'b0;
        de_in    = 1'b0;
        tick();
        total++;
        if (ft2 !== 1'b1) $display("FAIL frame_tick_pulse got %b exp 1", ft2);
        else passed++;
        vsync_in = 1'b1;
        tick();
        total++;
        if (ft2 !== 1'b0) $display("FAIL frame_tick_clear got %b exp 0", ft2);
        else passed++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ticks(2);
        total++;
        if ({hs2, vs2, rgb2, ft2, st2} !== {1'b1, 1'b1, 12'h000, 1'b0, 2'b00})
            $display("FAIL reset_outputs got hs=%b vs=%b rgb=%h ft=%b st=%b exp 1 1 000 0 00",
                     hs2, vs2, rgb2, ft2, st2);
        else passed++;
        total++;
        if ({hs4, vs4, rgb4} !== {1'b1, 1'b1, 12'h000})
            $display("FAIL reset_outputs_p4 got hs=%b vs=%b rgb=%h exp 1 1 000", hs4, vs4, rgb4);
        else passed++;
        reset = 1'b0;
        ticks(1);
    endtask

    task automatic test_compose();
        de_in     = 1'b1;
        layer_hit = 3'b110;
        layer_rgb = {12'hF00, 12'h999, 12'h777};
        tick();
        total++;
        if (rgb2 !== 12'h000) $display("FAIL compose_latency got %h exp 000", rgb2);
        else passed++;
        tick();
        total++;
        if (rgb2 !== 12'h999) $display("FAIL compose_layer1 got %h exp 999", rgb2);
        else passed++;
        layer_hit = 3'b000;
        bg_rgb    = 12'h222;
        ticks(2);
        total++;
        if (rgb2 !== 12'h222) $display("FAIL compose_bg got %h exp 222", rgb2);
        else passed++;
        layer_hit = 3'b111;
        layer_rgb = {12'hF00, 12'h999, 12'h123};
        ticks(2);
        total++;
        if (rgb2 !== 12'h123) $display("FAIL compose_layer0 got %h exp 123", rgb2);
        else passed++;
        layer_hit = 3'b100;
        ticks(2);
        total++;
        if (rgb2 !== 12'hF00) $display("FAIL compose_layer2 got %h exp F00", rgb2);
        else passed++;
        hsync_in = 1'b0;
        tick();
        total++;
        if (hs2 !== 1'b1) $display("FAIL hsync_early got %b exp 1", hs2);
        else passed++;
        tick();
        total++;
        if (hs2 !== 1'b0) $display("FAIL hsync_delayed got %b exp 0", hs2);
        else passed++;
        hsync_in = 1'b1;
        de_in    = 1'b0;
        ticks(2);
        total++;
        if (rgb2 !== 12'h000 || hs2 !== 1'b1) $display("FAIL de_low got rgb=%h hs=%b exp 000 1", rgb2, hs2);
        else passed++;
    endtask

    task automatic test_pause();
        layer_hit = 3'b001;
        layer_rgb = {12'hF00, 12'h999, 12'hA53};
        de_in     = 1'b1;
        mode      = 2'b01;
        ticks(3);
        total++;
        if (rgb2 !== 12'hA53 || st2 !== 2'b00)
            $display("FAIL pause_midframe got rgb=%h st=%b exp A53 00", rgb2, st2);
        else passed++;
        frame_start();
        de_in = 1'b1;
        ticks(2);
        total++;
        if (rgb2 !== 12'h521 || st2 !== 2'b01)
            $display("FAIL pause_dim got rgb=%h st=%b exp 521 01", rgb2, st2);
        else passed++;
        mode = 2'b00;
        ticks(2);
        total++;
        if (rgb2 !== 12'h521 || st2 !== 2'b01)
            $display("FAIL pause_hold_midframe got rgb=%h st=%b exp 521 01", rgb2, st2);
        else passed++;
    endtask

    task automatic test_flash();
        logic [11:0] exp_rgb;
        over_rgb = 12'h00F;
        mode     = 2'b10;
        frame_start();
        total++;
        if (st2 !== 2'b10) $display("FAIL flash_entry got st=%b exp 10", st2);
        else passed++;
        for (int k = 0; k < 8; k++) begin
            if (k == 3) mode = 2'b01;
            de_in = 1'b1;
            ticks(2);
            exp_rgb = ((k % 4) >= 2) ? 12'h00F : 12'hA53;
            total++;
            if (rgb2 !== exp_rgb || st2 !== 2'b10)
                $display("FAIL flash_frame%0d got rgb=%h st=%b exp %h 10", k, rgb2, st2, exp_rgb);
            else passed++;
            frame_start();
        end
        de_in = 1'b1;
        ticks(3);
        total++;
        if (rgb2 !== 12'h00F || st2 !== 2'b11)
            $display("FAIL hold_entry got rgb=%h st=%b exp 00F 11", rgb2, st2);
        else passed++;
        mode = 2'b10;
        frame_start();
        de_in = 1'b1;
        ticks(2);
        total++;
        if (rgb2 !== 12'h00F || st2 !== 2'b11)
            $display("FAIL hold_no_restart got rgb=%h st=%b exp 00F 11", rgb2, st2);
        else passed++;
        mode = 2'b00;
        ticks(2);
        total++;
        if (rgb2 !== 12'h00F || st2 !== 2'b11)
            $display("FAIL hold_midframe_play got rgb=%h st=%b exp 00F 11", rgb2, st2);
        else passed++;
        frame_start();
        de_in = 1'b1;
        ticks(2);
        total++;
        if (rgb2 !== 12'hA53 || st2 !== 2'b00)
            $display("FAIL hold_to_play got rgb=%h st=%b exp A53 00", rgb2, st2);
        else passed++;
    endtask

    task automatic test_reset_mid_flash();
        logic seen;
        mode = 2'b11;
        frame_start();
        de_in = 1'b1;
        ticks(3);
        total++;
        if (st2 !== 2'b10) $display("FAIL mode11_flash got st=%b exp 10", st2);
        else passed++;
        vsync_in = 1'b0;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
        de_in = 1'b0;
        total++;
        if ({hs2, vs2, rgb2, st2, ft2} !== {1'b1, 1'b1, 12'h000, 2'b00, 1'b0})
            $display("FAIL reset_mid_flash got hs=%b vs=%b rgb=%h st=%b ft=%b exp 1 1 000 00 0",
                     hs2, vs2, rgb2, st2, ft2);
        else passed++;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            seen = seen | ft2;
        end
        total++;
        if (seen !== 1'b0 || st2 !== 2'b00)
            $display("FAIL no_false_tick got seen=%b st=%b exp 0 00", seen, st2);
        else passed++;
        vsync_in = 1'b1;
        tick();
        vsync_in = 1'b0;
        tick();
        total++;
        if (ft2 !== 1'b1) $display("FAIL true_edge_tick got %b exp 1", ft2);
        else passed++;
        vsync_in = 1'b1;
        tick();
        total++;
        if (st2 !== 2'b10) $display("FAIL reflash_after_reset got st=%b exp 10", st2);
        else passed++;
        mode = 2'b00;
        frame_start();
        total++;
        if (st2 !== 2'b00) $display("FAIL back_to_play got st=%b exp 00", st2);
        else passed++;
    endtask

    task automatic test_sync_align();
        int ch2, ch4, first4, nz4;
        ch2 = -1; ch4 = -1; first4 = -1; nz4 = 0;
        pix_en    = 1'b1;
        hsync_in  = 1'b1;
        de_in     = 1'b0;
        layer_hit = 3'b000;
        bg_rgb    = 12'h222;
        ticks(6);
        for (int c = 0; c < 40; c++) begin
            pix_en = ((c % 4) == 3);
            if (c == 4) begin
                hsync_in = 1'b0;
                de_in    = 1'b1;
            end
            if (c == 8) de_in = 1'b0;
            tick();
            if (hs2 == 1'b0 && ch2 < 0) ch2 = c;
            if (hs4 == 1'b0 && ch4 < 0) ch4 = c;
            if (rgb4 != 12'h000) begin
                nz4++;
                if (first4 < 0) first4 = c;
            end
        end
        // input edge was driven just after the strobe edge at c=3
        total++;
        if (ch2 - 3 !== 8) $display("FAIL hsync_lag_p2 got %0d exp 8", ch2 - 3);
        else passed++;
        total++;
        if (ch4 - 3 !== 16) $display("FAIL hsync_lag_p4 got %0d exp 16", ch4 - 3);
        else passed++;
        total++;
        if (first4 !== 19 || nz4 !== 4)
            $display("FAIL de_window_p4 got first=%0d count=%0d exp 19 4", first4, nz4);
        else passed++;
        hsync_in = 1'b1;
        pix_en   = 1'b1;
        ticks(2);
    endtask

    initial begin
        reset     = 1'b1;
        pix_en    = 1'b1;
        hsync_in  = 1'b1;
        vsync_in  = 1'b1;
        de_in     = 1'b0;
        layer_hit = '0;
        layer_rgb = '0;
        bg_rgb    = '0;
        over_rgb  = '0;
        mode      = 2'b00;
        test_reset();
        test_compose();
        test_pause();
        test_flash();
        test_reset_mid_flash();
        test_sync_align();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
